// File: rtl/serial_rx_frame_pkg.sv
// Shared constants, FSM state encoding and elaboration helpers for the serial frame receiver.
package serial_rx_frame_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) result = result + 32'sd1;
    return result;
  endfunction

endpackage

// File: rtl/serial_rx_frame_bit_sync.sv
// Multi-flop synchroniser for the asynchronous serial pin; flops reset to the idle-high level.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // shift the pin through the flop chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '1;
    end else begin
      sync_r[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/serial_rx_frame.sv
// Oversampling asynchronous serial frame receiver with parity, framing and overrun reporting
// and a valid/ready holding register towards the consumer.
module serial_rx_frame
  import serial_rx_frame_pkg::*;
#(
  parameter int DATA_BITS    = 7,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int PW   = clog2(CLKS_PER_BIT) + 1;
  localparam int CW   = clog2(DATA_BITS + 1);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;

  localparam logic [PW-1:0] PHASE_BIT  = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_HALF = PW'((HALF > 0) ? (HALF - 1) : 0);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] LAST_DATA  = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP  = CW'(STOP_BITS - 1);

  function automatic logic parity_expect(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == PARITY_ODD) ? ~^d : ^d;
  endfunction

  logic                 serial_s;
  state_t               state_r, state_next;
  logic [PW-1:0]        phase_r, phase_next;
  logic [CW-1:0]        cnt_r, cnt_next;
  logic [DATA_BITS-1:0] shift_r, shift_next;
  logic                 par_bad_r, stop_bad_r;
  logic                 sample_s, shift_en_s, par_en_s, stop_en_s, commit_s;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (serial_s)
      );
    end else begin : g_nosync
      assign serial_s = serial_in;
    end
  endgenerate

  // FSM state, phase and bit counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      phase_r <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next;
      phase_r <= phase_next;
      cnt_r   <= cnt_next;
    end
  end

  // next-state and per-cycle sample strobes
  always_comb begin
    state_next = state_r;
    phase_next = phase_r;
    cnt_next   = cnt_r;
    shift_en_s = 1'b0;
    par_en_s   = 1'b0;
    stop_en_s  = 1'b0;
    commit_s   = 1'b0;
    sample_s   = (phase_r == '0);
    case (state_r)
      ST_IDLE: begin
        if (!serial_s) begin
          cnt_next = '0;
          // with no room before mid-start, the detect cycle doubles as the start sample
          if (HALF == 0) begin
            state_next = ST_DATA;
            phase_next = PHASE_BIT;
          end else begin
            state_next = ST_START;
            phase_next = PHASE_HALF;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (!sample_s) begin
          phase_next = phase_r - PHASE_ONE;
        end else if (serial_s) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_DATA;
          phase_next = PHASE_BIT;
        end
      end
      ST_DATA: begin
        if (!sample_s) begin
          phase_next = phase_r - PHASE_ONE;
        end else begin
          shift_en_s = 1'b1;
          phase_next = PHASE_BIT;
          if (cnt_r == LAST_DATA) begin
            cnt_next   = '0;
            state_next = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            cnt_next = cnt_r + CNT_ONE;
          end
        end
      end
      ST_PARITY: begin
        if (!sample_s) begin
          phase_next = phase_r - PHASE_ONE;
        end else begin
          par_en_s   = 1'b1;
          phase_next = PHASE_BIT;
          cnt_next   = '0;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!sample_s) begin
          phase_next = phase_r - PHASE_ONE;
        end else begin
          stop_en_s  = 1'b1;
          phase_next = PHASE_BIT;
          if (cnt_r == LAST_STOP) begin
            commit_s   = 1'b1;
            cnt_next   = '0;
            state_next = serial_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            cnt_next = cnt_r + CNT_ONE;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (serial_s) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // shift-in LSB first: each new bit enters at the top
  always_comb begin
    shift_next = shift_r;
    for (int i = 0; i < DATA_BITS - 1; i++) shift_next[i] = shift_r[i+1];
    shift_next[DATA_BITS-1] = serial_s;
  end

  // frame datapath: payload shifter and per-frame error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r    <= '0;
      par_bad_r  <= 1'b0;
      stop_bad_r <= 1'b0;
    end else begin
      if (shift_en_s) shift_r <= shift_next;
      if (par_en_s) par_bad_r <= (serial_s != parity_expect(shift_r));
      if (state_r == ST_IDLE) begin
        stop_bad_r <= 1'b0;
      end else if (stop_en_s && !serial_s) begin
        stop_bad_r <= 1'b1;
      end
    end
  end

  // holding register and consumer handshake; a commit always wins over an accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE);
      if (commit_s) begin
        data_out   <= shift_r;
        parity_err <= (PARITY_MODE != PARITY_NONE) && par_bad_r;
        frame_err  <= stop_bad_r | ~serial_s;
        data_valid <= 1'b1;
        overrun    <= data_valid & ~data_ready;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_frame.sv
// Scoreboard bench: three receiver configurations driven with directed frames; a monitor per
// instance checks every accepted word against the expected queue.
module tb_serial_rx_frame;

  typedef struct packed {
    logic [6:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_a = 1'b1, ser_b = 1'b1, ser_c = 1'b1;
  logic rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;
  logic [6:0] do_a, do_b, do_c;
  logic dv_a, dv_b, dv_c, pe_a, pe_b, pe_c, fe_a, fe_b, fe_c;
  logic ov_a, ov_b, ov_c, bz_a, bz_b, bz_c;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int total = 0;
  int bad = 0;
  logic [15:0] fr;
  logic saw_busy;

  always #5 clk = ~clk;

  serial_rx_frame #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(1), .SYNC_STAGES(0)) u_a (
    .clk(clk), .rst(rst), .serial_in(ser_a), .data_out(do_a), .data_valid(dv_a), .data_ready(rdy_a),
    .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a), .busy(bz_a));

  serial_rx_frame #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1), .CLKS_PER_BIT(1), .SYNC_STAGES(0)) u_b (
    .clk(clk), .rst(rst), .serial_in(ser_b), .data_out(do_b), .data_valid(dv_b), .data_ready(rdy_b),
    .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b), .busy(bz_b));

  serial_rx_frame #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(4), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst(rst), .serial_in(ser_c), .data_out(do_c), .data_valid(dv_c), .data_ready(rdy_c),
    .parity_err(pe_c), .frame_err(fe_c), .overrun(ov_c), .busy(bz_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string tag, input exp_t e, input logic [6:0] d,
                           input logic pe, input logic fe, input logic ov);
    check({tag, "_data"}, 32'(d), 32'(e.data));
    check({tag, "_parity_err"}, 32'(pe), 32'(e.perr));
    check({tag, "_frame_err"}, 32'(fe), 32'(e.ferr));
    check({tag, "_overrun"}, 32'(ov), 32'(e.ovr));
  endtask

  task automatic unexpected(input string tag);
    total++;
    bad++;
    $display("FAIL %s_unexpected_word: got a word, expected none", tag);
  endtask

  // monitors: compare whenever a word is handed over
  always @(negedge clk) if (dv_a && rdy_a) begin
    if (qa.size() == 0) unexpected("a"); else pop_check("a", qa.pop_front(), do_a, pe_a, fe_a, ov_a);
  end
  always @(negedge clk) if (dv_b && rdy_b) begin
    if (qb.size() == 0) unexpected("b"); else pop_check("b", qb.pop_front(), do_b, pe_b, fe_b, ov_b);
  end
  always @(negedge clk) if (dv_c && rdy_c) begin
    if (qc.size() == 0) unexpected("c"); else pop_check("c", qc.pop_front(), do_c, pe_c, fe_c, ov_c);
  end

  function automatic logic [15:0] frame(input logic [6:0] d, input logic p, input logic s);
    return {6'b000000, s, p, d, 1'b0};
  endfunction

  function automatic logic dv_of(input int sel);
    case (sel)
      0: return dv_a;
      1: return dv_b;
      default: return dv_c;
    endcase
  endfunction

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0: ser_a = v;
      1: ser_b = v;
      default: ser_c = v;
    endcase
  endtask

  task automatic set_rdy(input int sel, input logic v);
    case (sel)
      0: rdy_a = v;
      1: rdy_b = v;
      default: rdy_c = v;
    endcase
  endtask

  task automatic send(input int sel, input logic [15:0] bits, input int n, input int cpb);
    for (int i = 0; i < n; i++) begin
      set_line(sel, bits[i]);
      repeat (cpb) @(posedge clk);
      #1;
    end
    set_line(sel, 1'b1);
  endtask

  task automatic accept(input int sel);
    int waited;
    waited = 0;
    while (!dv_of(sel) && waited < 60) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check($sformatf("valid_before_accept_%0d", sel), 32'(dv_of(sel)), 32'd1);
    set_rdy(sel, 1'b1);
    @(posedge clk);
    #1;
    set_rdy(sel, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_data_out", 32'(do_a), 32'd0);
    check("rst_data_valid", 32'(dv_a), 32'd0);
    check("rst_parity_err", 32'(pe_a), 32'd0);
    check("rst_frame_err", 32'(fe_a), 32'd0);
    check("rst_overrun", 32'(ov_a), 32'd0);
    check("rst_busy", 32'(bz_a), 32'd0);
    check("rst_busy_c", 32'(bz_c), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // 1: clean 0x41, latency and hold
    qa.push_back('{data: 7'h41, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    fr = frame(7'h41, 1'b0, 1'b1);
    send(0, fr, 1, 1);
    check("t1_busy_after_start", 32'(bz_a), 32'd1);
    send(0, fr >> 1, 8, 1);
    check("t1_valid_not_early", 32'(dv_a), 32'd0);
    send(0, fr >> 9, 1, 1);
    check("t1_valid_rise", 32'(dv_a), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t1_valid_held", 32'(dv_a), 32'd1);
    check("t1_data_held", 32'(do_a), 32'h41);
    accept(0);
    check("t1_valid_cleared", 32'(dv_a), 32'd0);

    // 2: wrong even parity; same line on odd-parity instance is correct
    qa.push_back('{data: 7'h41, perr: 1'b1, ferr: 1'b0, ovr: 1'b0});
    send(0, frame(7'h41, 1'b1, 1'b1), 10, 1);
    accept(0);
    qb.push_back('{data: 7'h41, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send(1, frame(7'h41, 1'b1, 1'b1), 10, 1);
    accept(1);

    // 3: stop bit 0 with line held low, then a clean 0x12
    qa.push_back('{data: 7'h41, perr: 1'b0, ferr: 1'b1, ovr: 1'b0});
    fr = frame(7'h41, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ser_a = fr[i];
      @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    check("t3_wait_high_busy", 32'(bz_a), 32'd1);
    accept(0);
    check("t3_no_new_frame", 32'(dv_a), 32'd0);
    ser_a = 1'b1;
    @(posedge clk);
    #1;
    check("t3_idle_after_high", 32'(bz_a), 32'd0);
    qa.push_back('{data: 7'h12, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send(0, frame(7'h12, 1'b0, 1'b1), 10, 1);
    accept(0);

    // 4: back-to-back 0x11, 0x22 unaccepted -> overrun
    qa.push_back('{data: 7'h22, perr: 1'b0, ferr: 1'b0, ovr: 1'b1});
    send(0, frame(7'h11, 1'b0, 1'b1), 10, 1);
    send(0, frame(7'h22, 1'b0, 1'b1), 10, 1);
    check("t4_overrun_flag", 32'(ov_a), 32'd1);
    accept(0);
    check("t4_overrun_cleared", 32'(ov_a), 32'd0);
    check("t4_valid_cleared", 32'(dv_a), 32'd0);

    // 4b: accept on the same edge as the next commit
    qa.push_back('{data: 7'h11, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    qa.push_back('{data: 7'h22, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send(0, frame(7'h11, 1'b0, 1'b1), 10, 1);
    fr = frame(7'h22, 1'b0, 1'b1);
    send(0, fr, 9, 1);
    rdy_a = 1'b1;
    send(0, fr >> 9, 1, 1);
    rdy_a = 1'b0;
    check("t4b_valid_kept", 32'(dv_a), 32'd1);
    check("t4b_new_data", 32'(do_a), 32'h22);
    accept(0);

    // 5: oversampled instance, glitch reject then 0x55
    saw_busy = 1'b0;
    ser_c = 1'b0;
    @(posedge clk);
    #1;
    ser_c = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bz_c) saw_busy = 1'b1;
    end
    check("t5_glitch_seen_busy", 32'(saw_busy), 32'd1);
    check("t5_glitch_busy_low", 32'(bz_c), 32'd0);
    check("t5_glitch_no_valid", 32'(dv_c), 32'd0);
    qc.push_back('{data: 7'h55, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send(2, frame(7'h55, 1'b0, 1'b1), 10, 4);
    accept(2);

    // 6: reset during data bit 3 of 0x7F, then 0x05
    fr = frame(7'h7F, 1'b1, 1'b1);
    send(0, fr, 4, 1);
    ser_a = fr[4];
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(bz_a), 32'd0);
    check("t6_rst_valid", 32'(dv_a), 32'd0);
    check("t6_rst_data", 32'(do_a), 32'd0);
    check("t6_rst_errs", 32'({pe_a, fe_a, ov_a}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(0, fr >> 5, 5, 1);
    repeat (4) @(posedge clk);
    #1;
    check("t6_no_partial_word", 32'(dv_a), 32'd0);
    qa.push_back('{data: 7'h05, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send(0, frame(7'h05, 1'b0, 1'b1), 10, 1);
    accept(0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_a_drained", 32'(qa.size()), 32'd0);
    check("queue_b_drained", 32'(qb.size()), 32'd0);
    check("queue_c_drained", 32'(qc.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
